mdv_ctrl: RTL and testbench

//  ZX8302-side microdrive controller sitting directly downstream of the mdv replay blocks.

---
 rtl/mdv_pkg.sv | 26 ++
 rtl/mdv_rx_fifo.sv | 81 ++++++++
 rtl/mdv_ctrl.sv | 131 +++++++++++++
 tb/tb_mdv_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mdv_pkg                                                         |
// | Purpose  : Shared constants for the ZX8302-side microdrive controller:     |
// |            status/control register bit positions and the drive limit.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mdv_pkg;

  // Upper bound on attached drives; the select register is always this wide.
  localparam int c_NUM_DRV_MAX  = 8;

  // Control register bit positions
  localparam int c_CTRL_SEL_DATA = 0;
  localparam int c_CTRL_SEL_CLK  = 1;
  localparam int c_CTRL_FLUSH    = 3;

  // Status register bit positions
  localparam int c_STS_GAP       = 0;
  localparam int c_STS_RX_AVAIL  = 1;
  localparam int c_STS_OVERRUN   = 2;
  localparam int c_STS_TX_EMPTY  = 3;
  localparam int c_STS_IRQ_GAP   = 4;

endpackage : mdv_pkg
`default_nettype wire

// File: rtl/mdv_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mdv_rx_fifo                                                     |
// | Purpose  : Synchronous receive byte FIFO with flush and sticky overrun.    |
// | Ports    : clk, reset (async, active high)                                 |
// |            push_i/din_i   write a byte (dropped + overrun when full)       |
// |            pop_i          remove head (ignored when empty)                 |
// |            flush_i        empty FIFO, clear overrun, discard push          |
// |            dout_o         head byte, 8'h00 when empty                      |
// |            empty_o, full_o, overrun_o                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mdv_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [7:0] dout_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overrun_q, overrun_d;
  logic        do_pop_w;
  logic        do_push_w;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so push-while-full with a pop succeeds.
  assign do_pop_w  = pop_i & ~empty_o & ~flush_i;
  assign do_push_w = push_i & ~flush_i & (~full_o | do_pop_w);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (flush_i) begin
      rd_ptr_d  = wr_ptr_q;
      overrun_d = 1'b0;
    end else begin
      if (do_pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push_w) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push_i && !do_push_w) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset: contents are only visible through a valid pointer.
  always_ff @(posedge clk) begin
    if (do_push_w) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o    = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign overrun_o = overrun_q;

endmodule : mdv_rx_fifo
`default_nettype wire

// File: rtl/mdv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mdv_ctrl                                                        |
// | Purpose  : ZX8302-side microdrive controller. Serial drive-select shift    |
// |            register, gap/rx/data mux from the selected drive, rx byte      |
// |            FIFO and gap interrupt, presented as status and data bytes.     |
// | Ports    : clk, reset (async, active high), ce (CPU clock enable)          |
// |            ctrl_wr/ctrl_din  control write: [0] sel data, [1] sel clock,   |
// |                              [3] FIFO flush                                |
// |            data_rd           pop rx FIFO;  irq_ack  clear gap interrupt    |
// |            mdv_gap/mdv_rx_ready/mdv_dout  per-drive inputs                 |
// |            mdv_sel, status, data_out, irq_gap                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mdv_ctrl
  import mdv_pkg::*;
#(
  parameter int NUM_DRV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 ctrl_wr,
  input  logic [7:0]           ctrl_din,
  input  logic                 data_rd,
  input  logic                 irq_ack,
  input  logic [NUM_DRV-1:0]   mdv_gap,
  input  logic [NUM_DRV-1:0]   mdv_rx_ready,
  input  logic [8*NUM_DRV-1:0] mdv_dout,
  output logic [7:0]           mdv_sel,
  output logic [7:0]           status,
  output logic [7:0]           data_out,
  output logic                 irq_gap
);

  logic [c_NUM_DRV_MAX-1:0] sel_q;
  logic       sel_clk_q;
  logic       gap_q, gap_prev_q;
  logic       rx_q, rx_prev_q;
  logic [7:0] dout_q;
  logic       irq_q;

  logic       wr_w, rd_w, ack_w;
  logic       gap_m, rx_m;
  logic [7:0] dout_m;
  logic       gap_rise_w, rx_rise_w, flush_w;
  logic       empty_w, full_w, overrun_w;
  logic       unused_w;

  assign wr_w  = ce & ctrl_wr;
  assign rd_w  = ce & data_rd;
  assign ack_w = ce & irq_ack;

  assign unused_w = ^{ctrl_din[7:4], ctrl_din[2], full_w};

  // Drive mux: scan downwards so the lowest set select bit wins.
  always_comb begin
    gap_m  = 1'b1;
    rx_m   = 1'b0;
    dout_m = 8'h00;
    for (int i = NUM_DRV - 1; i >= 0; i--) begin
      if (sel_q[i]) begin
        gap_m  = mdv_gap[i];
        rx_m   = mdv_rx_ready[i];
        dout_m = mdv_dout[8*i +: 8];
      end
    end
  end

  assign gap_rise_w = gap_q & ~gap_prev_q;
  assign rx_rise_w  = rx_q & ~rx_prev_q;
  // Entering a gap empties the FIFO so bytes never span a gap.
  assign flush_w    = (wr_w & ctrl_din[c_CTRL_FLUSH]) | gap_rise_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q      <= '0;
      sel_clk_q  <= 1'b0;
      // No drive is selected out of reset, which the mux reports as gap.
      gap_q      <= 1'b1;
      gap_prev_q <= 1'b1;
      rx_q       <= 1'b0;
      rx_prev_q  <= 1'b0;
      dout_q     <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      if (wr_w) begin
        sel_clk_q <= ctrl_din[c_CTRL_SEL_CLK];
        if (ctrl_din[c_CTRL_SEL_CLK] && !sel_clk_q)
          sel_q <= {sel_q[6:0], ctrl_din[c_CTRL_SEL_DATA]};
      end
      gap_q      <= gap_m;
      gap_prev_q <= gap_q;
      rx_q       <= rx_m;
      rx_prev_q  <= rx_q;
      dout_q     <= dout_m;
      if (gap_rise_w)  irq_q <= 1'b1;
      else if (ack_w)  irq_q <= 1'b0;
    end
  end

  mdv_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (rx_rise_w),
    .din_i     (dout_q),
    .pop_i     (rd_w),
    .flush_i   (flush_w),
    .dout_o    (data_out),
    .empty_o   (empty_w),
    .full_o    (full_w),
    .overrun_o (overrun_w)
  );

  always_comb begin
    status                 = 8'h00;
    status[c_STS_GAP]      = gap_q;
    status[c_STS_RX_AVAIL] = ~empty_w;
    status[c_STS_OVERRUN]  = overrun_w;
    status[c_STS_TX_EMPTY] = 1'b0;
    status[c_STS_IRQ_GAP]  = irq_q;
  end

  assign mdv_sel = sel_q;
  assign irq_gap = irq_q;

endmodule : mdv_ctrl
`default_nettype wire

// File: tb/tb_mdv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mdv_ctrl                                                     |
// | Purpose  : Self-checking bench for mdv_ctrl. Reads are checked by a        |
// |            scoreboard monitor; register state by direct compares.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mdv_ctrl;

  localparam int NUM_DRV = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ce;
  logic                 ctrl_wr;
  logic [7:0]           ctrl_din;
  logic                 data_rd;
  logic                 irq_ack;
  logic [NUM_DRV-1:0]   mdv_gap;
  logic [NUM_DRV-1:0]   mdv_rx_ready;
  logic [8*NUM_DRV-1:0] mdv_dout;
  logic [7:0]           mdv_sel;
  logic [7:0]           status;
  logic [7:0]           data_out;
  logic                 irq_gap;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  mdv_ctrl #(.NUM_DRV(NUM_DRV), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .ctrl_wr      (ctrl_wr),
    .ctrl_din     (ctrl_din),
    .data_rd      (data_rd),
    .irq_ack      (irq_ack),
    .mdv_gap      (mdv_gap),
    .mdv_rx_ready (mdv_rx_ready),
    .mdv_dout     (mdv_dout),
    .mdv_sel      (mdv_sel),
    .status       (status),
    .data_out     (data_out),
    .irq_gap      (irq_gap)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every ce-qualified read presents data_out for checking.
  always @(negedge clk) begin
    if (ce && data_rd) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got %02h, no expected byte queued", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL read_data: got %02h expected %02h", data_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic ctrl_write(input logic [7:0] d);
    ctrl_din = d;
    ctrl_wr  = 1'b1;
    tick();
    ctrl_wr  = 1'b0;
    tick();
  endtask

  // One sel-clock low/high pair shifting in bit b.
  task automatic sel_shift(input logic b);
    ctrl_write({7'b0, b});
    ctrl_write({6'b0, 1'b1, b});
  endtask

  task automatic rx_byte(input int drv, input logic [7:0] b);
    mdv_dout[8*drv +: 8] = b;
    mdv_rx_ready[drv]    = 1'b1;
    tick();
    mdv_rx_ready[drv]    = 1'b0;
    repeat (3) tick();
  endtask

  task automatic read_exp(input logic [7:0] b);
    exp_q.push_back(b);
    data_rd = 1'b1;
    tick();
    data_rd = 1'b0;
    tick();
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ce = 1'b1; ctrl_wr = 1'b0; ctrl_din = 8'h00;
    data_rd = 1'b0; irq_ack = 1'b0;
    mdv_gap = '0; mdv_rx_ready = '0; mdv_dout = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("reset_sel", mdv_sel, 8'h00);
    chk("reset_status", status, 8'h01);
    chk("reset_data", data_out, 8'h00);
    chk("reset_irq", {7'b0, irq_gap}, 8'h00);

    // Select shift: data 1,0,0,0 on four rising sel clocks
    sel_shift(1'b1); sel_shift(1'b0); sel_shift(1'b0); sel_shift(1'b0);
    ctrl_write(8'h03);              // sel clk stays 1: no shift
    chk("sel_shift", mdv_sel, 8'h08);
    repeat (3) tick();
    // Moving from drive 2 (no gap) to no drive is a gap edge
    chk("drive_change_irq", {7'b0, irq_gap}, 8'h01);
    ack();
    chk("irq_ack", {7'b0, irq_gap}, 8'h00);

    // Select drive 1
    sel_shift(1'b1);
    repeat (3) tick();
    chk("sel_drive1", mdv_sel, 8'h11);
    chk("status_drive1", status, 8'h00);

    // Capture three bytes
    rx_byte(0, 8'hA5); rx_byte(0, 8'h5A); rx_byte(0, 8'hFF);
    chk("capture_status", status, 8'h02);
    read_exp(8'hA5); read_exp(8'h5A); read_exp(8'hFF);
    chk("drained_status", status, 8'h00);
    chk("drained_data", data_out, 8'h00);
    read_exp(8'h00);                // read when empty: no effect
    chk("empty_read_status", status, 8'h00);

    // rx_ready held high pushes once; ce low blocks the pop
    mdv_dout[7:0] = 8'h3C; mdv_rx_ready[0] = 1'b1;
    repeat (5) tick();
    mdv_rx_ready[0] = 1'b0;
    repeat (3) tick();
    ce = 1'b0; data_rd = 1'b1; tick(); data_rd = 1'b0; ce = 1'b1; tick();
    chk("ce_gated_read", status, 8'h02);
    read_exp(8'h3C);
    chk("held_rx_single", status, 8'h00);

    // Overrun: five pushes into depth four
    rx_byte(0, 8'h11); rx_byte(0, 8'h22); rx_byte(0, 8'h33);
    rx_byte(0, 8'h44); rx_byte(0, 8'h55);
    chk("overrun_status", status, 8'h06);
    read_exp(8'h11); read_exp(8'h22);
    chk("overrun_sticky", status, 8'h06);
    ctrl_write(8'h08);
    chk("flush_status", status, 8'h00);

    // Push and pop on the same clock while full: no overrun
    rx_byte(0, 8'hA1); rx_byte(0, 8'hA2); rx_byte(0, 8'hA3); rx_byte(0, 8'hA4);
    mdv_dout[7:0] = 8'hB5; mdv_rx_ready[0] = 1'b1;
    tick();
    mdv_rx_ready[0] = 1'b0;
    exp_q.push_back(8'hA1); data_rd = 1'b1;
    tick();
    data_rd = 1'b0;
    repeat (3) tick();
    chk("full_push_pop", status, 8'h02);
    read_exp(8'hA2); read_exp(8'hA3); read_exp(8'hA4); read_exp(8'hB5);
    chk("full_push_pop_drain", status, 8'h00);

    // Gap interrupt flushes FIFO
    rx_byte(0, 8'h01); rx_byte(0, 8'h02);
    mdv_gap[0] = 1'b1;
    repeat (3) tick();
    chk("gap_irq_status", status, 8'h11);
    chk("gap_flush_data", data_out, 8'h00);
    mdv_gap[0] = 1'b0;
    repeat (3) tick();
    chk("gap_low_status", status, 8'h10);
    // Ack coincident with a new gap edge: set wins
    mdv_gap[0] = 1'b1;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    chk("ack_vs_set", {7'b0, irq_gap}, 8'h01);
    ack();
    chk("ack_after_set", {7'b0, irq_gap}, 8'h00);

    // No drive selected
    mdv_gap[0] = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) sel_shift(1'b0);
    repeat (3) tick();
    ack();
    chk("nodrive_sel", mdv_sel, 8'h00);
    chk("nodrive_status", status, 8'h01);
    rx_byte(0, 8'h77);
    chk("nodrive_no_push", status, 8'h01);
    chk("nodrive_data", data_out, 8'h00);

    // Reset mid-operation with three bytes queued and irq pending
    sel_shift(1'b1);
    repeat (3) tick();
    mdv_gap[0] = 1'b1; repeat (3) tick();
    mdv_gap[0] = 1'b0; repeat (3) tick();
    rx_byte(0, 8'hC1); rx_byte(0, 8'hC2); rx_byte(0, 8'hC3);
    chk("pre_reset_status", status, 8'h12);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_sel", mdv_sel, 8'h00);
    chk("async_reset_status", status, 8'h01);
    chk("async_reset_data", data_out, 8'h00);
    chk("async_reset_irq", {7'b0, irq_gap}, 8'h00);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("post_reset_status", status, 8'h01);

    chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mdv_ctrl
`default_nettype wire
